spmv_row_accum: RTL

- Final stage of the sparse matrix-vector datapath. Sits directly downstream of the level-3 map table and adder tree.
- Each input beat carries up to four 18-bit signed row-partial sums. The block merges partials that belong to a row spanning several beats, closes finished rows, and emits one completed row result per cycle with its row index.
- An internal result FIFO absorbs the burst of up to four rows closed in one beat. It applies valid/ready backpressure upstream.

---
 rtl/spmv_row_accum.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spmv_row_accum.sv
// spmv_row_accum: final stage of the sparse matrix-vector datapath.
//
// Merges up to four signed row-partial sums per input beat into row results.
// A row may span several beats; its running sum is held in the accumulator
// until a lane closes it. Closed rows are tagged with a running row index and
// queued in a first-word fall-through result FIFO. The FIFO drains one row
// per cycle.
//
// Optional feature (macro SPMV_ACC_SAT_EN):
//   defined   - the lane-0 add (acc + lane0) saturates, and sat_flag is sticky
//   undefined - the add wraps modulo 2^ACC_W, and sat_flag is tied to 0
//
// Ports:
//   clk, rst      clock; synchronous active-low reset
//   clear         synchronous soft clear (accumulator, row counter, FIFO)
//   in_valid      input beat valid
//   in_ready      at least four free FIFO entries
//   seg_data      four SEG_W partials; lane 0 in the MSBs
//   seg_cnt       number of valid lanes (values above 4 are treated as 4)
//   close_last    last valid lane closes its row
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts the head
//   out_data      head row sum (signed)
//   out_row       head row index
//   sat_flag      sticky saturation indicator
module spmv_row_accum #(
    parameter int unsigned SEG_W = 18,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned ROW_W = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*SEG_W-1:0] seg_data,
    input  logic [2:0]         seg_cnt,
    input  logic               close_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic [ROW_W-1:0]   out_row,
    output logic               sat_flag
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ROW_W-1:0]        row_cnt_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [ACC_W-1:0]        mem_data [DEPTH];
    logic [ROW_W-1:0]        mem_row  [DEPTH];

    logic                    accept;
    logic                    pop;
    logic                    soft_rst;
    logic [2:0]              n_lanes;
    logic [2:0]              push_cnt;
    logic signed [ACC_W-1:0] lane_ext [4];
    logic signed [ACC_W-1:0] push_val [4];
    logic signed [ACC_W-1:0] sum0;

    // Only registered occupancy counts; a pop in the same cycle is not credited.
    assign in_ready  = (count_q <= CNT_W'(DEPTH - 4));
    assign accept    = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign soft_rst  = !rst || clear;
    assign n_lanes   = (seg_cnt > 3'd4) ? 3'd4 : seg_cnt;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_ext[i] = ACC_W'($signed(seg_data[(4 - i) * SEG_W - 1 -: SEG_W]));
        end
    end

`ifdef SPMV_ACC_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           sat_event;
    logic           sat_q;

    // One guard bit exposes signed overflow: it must equal the sign bit.
    always_comb begin
        sum_wide  = {acc_q[ACC_W-1], acc_q} + {lane_ext[0][ACC_W-1], lane_ext[0]};
        sum0      = sum_wide[ACC_W-1:0];
        sat_event = 1'b0;
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sat_event = 1'b1;
            sum0      = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            sat_q <= 1'b0;
        end else if (accept && (n_lanes != 3'd0) && sat_event) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    assign sum0     = acc_q + lane_ext[0];
    assign sat_flag = 1'b0;
`endif

    // Lane 0 continues the open row; later lanes start fresh rows. Every
    // lane but the last closes; the last closes only with close_last.
    always_comb begin
        acc_d    = acc_q;
        push_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            push_val[i] = lane_ext[i];
        end
        push_val[0] = sum0;
        if (accept) begin
            if (n_lanes == 3'd0) begin
                // Empty beat with close_last terminates the open row as-is.
                push_val[0] = acc_q;
                if (close_last) begin
                    push_cnt = 3'd1;
                    acc_d    = '0;
                end
            end else begin
                push_cnt = n_lanes - 3'd1 + {2'b00, close_last};
                acc_d    = close_last ? '0 : push_val[2'(n_lanes - 3'd1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            acc_q     <= '0;
            row_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            acc_q     <= acc_d;
            row_cnt_q <= row_cnt_q + ROW_W'(push_cnt);
            wr_ptr_q  <= wr_ptr_q + PTR_W'(push_cnt);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q   <= count_q + CNT_W'(push_cnt) - CNT_W'(pop);
        end
    end

    // Storage is not reset; out_valid gates what is visible.
    always_ff @(posedge clk) begin
        if (!soft_rst) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < push_cnt) begin
                    mem_data[wr_ptr_q + PTR_W'(i)] <= push_val[i];
                    mem_row[wr_ptr_q + PTR_W'(i)]  <= row_cnt_q + ROW_W'(i);
                end
            end
        end
    end

    assign out_data = out_valid ? mem_data[rd_ptr_q] : '0;
    assign out_row  = out_valid ? mem_row[rd_ptr_q]  : '0;

endmodule
